// File: rtl/pipeline_hazard_controller_if.sv
// pipeline_hazard_controller_if: stage register indices, control bits and hazard-controller outputs
interface pipeline_hazard_controller_if #(parameter int CNT_W = 16);
  logic [1:0] id_rs;
  logic [1:0] id_rt;
  logic id_uses_rs;
  logic id_uses_rt;
  logic id_jump;
  logic id_halt;
  logic [1:0] ex_dest;
  logic [1:0] mem_dest;
  logic [1:0] wb_dest;
  logic ex_reg_write;
  logic mem_reg_write;
  logic wb_reg_write;
  logic ex_mem_read;
  logic ex_redirect;
  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_stall;
  logic id_ex_bubble;
  logic halted;
  logic [CNT_W-1:0] stall_cycles;
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, id_halt,
    output ex_dest, mem_dest, wb_dest, ex_reg_write, mem_reg_write, wb_reg_write,
    output ex_mem_read, ex_redirect,
    input  pc_write, if_id_write, if_id_flush, id_ex_stall, id_ex_bubble, halted, stall_cycles
  );
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, id_halt,
    input  ex_dest, mem_dest, wb_dest, ex_reg_write, mem_reg_write, wb_reg_write,
    input  ex_mem_read, ex_redirect,
    output pc_write, if_id_write, if_id_flush, id_ex_stall, id_ex_bubble, halted, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush/halt sequencing for the 5-stage pipeline
// Define HAZARD_FORWARDING_EN when the datapath forwards from EX/MEM and MEM/WB.
module pipeline_hazard_controller #(
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset_n,
  pipeline_hazard_controller_if.slave bus
);
  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALTED} state_t;
  state_t state, state_nx;
  logic [1:0] drain, drain_nx;
  logic [CNT_W-1:0] cnt;
  logic hazard, ex_hit;
  logic pc_write, if_id_write, if_id_flush, id_ex_stall, id_ex_bubble;
  assign ex_hit = (bus.id_uses_rs && bus.id_rs == bus.ex_dest) || (bus.id_uses_rt && bus.id_rt == bus.ex_dest);
`ifdef HAZARD_FORWARDING_EN
  assign hazard = ex_hit && bus.ex_mem_read && bus.ex_reg_write;
`else
  logic mem_hit, wb_hit;
  assign mem_hit = (bus.id_uses_rs && bus.id_rs == bus.mem_dest) || (bus.id_uses_rt && bus.id_rt == bus.mem_dest);
  assign wb_hit  = (bus.id_uses_rs && bus.id_rs == bus.wb_dest) || (bus.id_uses_rt && bus.id_rt == bus.wb_dest);
  assign hazard  = (ex_hit && bus.ex_reg_write) || (mem_hit && bus.mem_reg_write) || (wb_hit && bus.wb_reg_write);
`endif
  always_comb begin
    state_nx = state;
    drain_nx = drain;
    pc_write = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_stall = 1'b0;
    id_ex_bubble = 1'b0;
    case (state)
      RUN: begin
        if (bus.ex_redirect) begin
          id_ex_bubble = 1'b1;
          if_id_flush = 1'b1;
          pc_write = 1'b1;
          state_nx = FLUSH;
        end else if (hazard) begin
          id_ex_stall = 1'b1;
        end else if (bus.id_jump) begin
          if_id_flush = 1'b1;
          pc_write = 1'b1;
        end else if (bus.id_halt) begin
          id_ex_stall = 1'b1;
          drain_nx = 2'd2;
          state_nx = DRAIN;
        end else begin
          pc_write = 1'b1;
          if_id_write = 1'b1;
        end
      end
      FLUSH: begin
        pc_write = 1'b1;
        if_id_write = 1'b1;
        state_nx = RUN;
      end
      DRAIN: begin
        id_ex_stall = 1'b1;
        drain_nx = drain - 2'd1;
        state_nx = drain <= 2'd1 ? HALTED : DRAIN;
      end
      default: id_ex_stall = 1'b1;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      drain <= 2'd0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      drain <= drain_nx;
      if ((state == RUN || state == DRAIN) && !pc_write && cnt != '1)
        cnt <= cnt + 1'b1;
    end
  end
  // Controls are forced low while reset is held, whatever the inputs.
  assign bus.pc_write     = reset_n && pc_write;
  assign bus.if_id_write  = reset_n && if_id_write;
  assign bus.if_id_flush  = reset_n && if_id_flush;
  assign bus.id_ex_stall  = reset_n && id_ex_stall;
  assign bus.id_ex_bubble = reset_n && id_ex_bubble;
  assign bus.halted       = reset_n && state == HALTED;
  assign bus.stall_cycles = cnt;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed vectors for the hazard controller, CNT_W=4
module tb_pipeline_hazard_controller;
`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [5:0] RUNC = 6'b110000, STALL = 6'b000100, REDIR = 6'b101010;
  localparam logic [5:0] JUMP = 6'b101000, HALT = 6'b000101, ZERO = 6'b000000;
  logic clk = 1'b0;
  logic reset_n;
  int vectors = 0;
  int miscompares = 0;
  logic [5:0] ctl;
  pipeline_hazard_controller_if #(.CNT_W(4)) bus ();
  pipeline_hazard_controller #(.CNT_W(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  assign ctl = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_stall, bus.id_ex_bubble, bus.halted};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask
  task automatic idle();
    bus.id_rs = 2'd0; bus.id_rt = 2'd0; bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
    bus.id_jump = 1'b0; bus.id_halt = 1'b0;
    bus.ex_dest = 2'd0; bus.mem_dest = 2'd0; bus.wb_dest = 2'd0;
    bus.ex_reg_write = 1'b0; bus.mem_reg_write = 1'b0; bus.wb_reg_write = 1'b0;
    bus.ex_mem_read = 1'b0; bus.ex_redirect = 1'b0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load_hazard(input logic [1:0] r);
    bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_dest = r;
    bus.id_rs = r; bus.id_uses_rs = 1'b1;
  endtask
  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask
  initial begin
    reset_n = 1'b0;
    idle();
    bus.id_halt = 1'b1; bus.ex_redirect = 1'b1;
    @(negedge clk);
    chk("reset_ctl", {2'b0, ctl}, {2'b0, ZERO});
    chk("reset_cnt", {4'b0, bus.stall_cycles}, 8'd0);
    tick();
    idle();
    reset_n = 1'b1;
    @(negedge clk);
    chk("run_idle", {2'b0, ctl}, {2'b0, RUNC});
    tick();
    load_hazard(2'd2);
    @(negedge clk);
    chk("loaduse_stall", {2'b0, ctl}, {2'b0, STALL});
    chk("loaduse_cnt0", {4'b0, bus.stall_cycles}, 8'd0);
    tick();
    bus.ex_mem_read = 1'b0; bus.ex_reg_write = 1'b0; bus.ex_dest = 2'd0;
    bus.mem_dest = 2'd2; bus.mem_reg_write = 1'b1;
    @(negedge clk);
    chk("loaduse_after", {2'b0, ctl}, {2'b0, FWD ? RUNC : STALL});
    chk("loaduse_cnt1", {4'b0, bus.stall_cycles}, 8'd1);
    tick();
    idle();
    load_hazard(2'd2);
    bus.id_uses_rs = 1'b0;
    @(negedge clk);
    chk("rs_unused", {2'b0, ctl}, {2'b0, RUNC});
    bus.id_rt = 2'd2; bus.id_uses_rt = 1'b1;
    @(negedge clk);
    chk("rt_match", {2'b0, ctl}, {2'b0, STALL});
    do_reset();
    bus.ex_dest = 2'd1; bus.ex_reg_write = 1'b1; bus.id_rs = 2'd1; bus.id_uses_rs = 1'b1;
    @(negedge clk);
    chk("alu_ex", {2'b0, ctl}, {2'b0, FWD ? RUNC : STALL});
    tick();
    bus.ex_reg_write = 1'b0; bus.ex_dest = 2'd0; bus.mem_dest = 2'd1; bus.mem_reg_write = 1'b1;
    @(negedge clk);
    chk("alu_mem", {2'b0, ctl}, {2'b0, FWD ? RUNC : STALL});
    tick();
    bus.mem_reg_write = 1'b0; bus.mem_dest = 2'd0; bus.wb_dest = 2'd1; bus.wb_reg_write = 1'b1;
    @(negedge clk);
    chk("alu_wb", {2'b0, ctl}, {2'b0, FWD ? RUNC : STALL});
    tick();
    bus.wb_reg_write = 1'b0; bus.wb_dest = 2'd0;
    @(negedge clk);
    chk("alu_done", {2'b0, ctl}, {2'b0, RUNC});
    chk("alu_cnt", {4'b0, bus.stall_cycles}, FWD ? 8'd0 : 8'd3);
    bus.mem_dest = 2'd1;
    @(negedge clk);
    chk("mem_nowrite", {2'b0, ctl}, {2'b0, RUNC});
    do_reset();
    load_hazard(2'd3);
    bus.id_halt = 1'b1; bus.ex_redirect = 1'b1;
    @(negedge clk);
    chk("redirect", {2'b0, ctl}, {2'b0, REDIR});
    tick();
    @(negedge clk);
    chk("flush_masked", {2'b0, ctl}, {2'b0, RUNC});
    tick();
    idle();
    @(negedge clk);
    chk("no_drain", {2'b0, ctl}, {2'b0, RUNC});
    chk("redirect_cnt", {4'b0, bus.stall_cycles}, 8'd0);
    bus.id_jump = 1'b1;
    @(negedge clk);
    chk("jump", {2'b0, ctl}, {2'b0, JUMP});
    load_hazard(2'd1);
    @(negedge clk);
    chk("jump_hazard", {2'b0, ctl}, {2'b0, STALL});
    do_reset();
    bus.id_halt = 1'b1;
    @(negedge clk);
    chk("halt_t0", {2'b0, ctl}, {2'b0, STALL});
    tick();
    @(negedge clk);
    chk("halt_t1", {2'b0, ctl}, {2'b0, STALL});
    tick();
    bus.id_halt = 1'b0;
    @(negedge clk);
    chk("halt_t2", {2'b0, ctl}, {2'b0, STALL});
    tick();
    @(negedge clk);
    chk("halt_t3", {2'b0, ctl}, {2'b0, HALT});
    chk("halt_cnt", {4'b0, bus.stall_cycles}, 8'd3);
    tick();
    bus.ex_redirect = 1'b1;
    @(negedge clk);
    chk("halted_redirect", {2'b0, ctl}, {2'b0, HALT});
    tick();
    tick();
    bus.ex_redirect = 1'b0;
    @(negedge clk);
    chk("halted_hold", {2'b0, ctl}, {2'b0, HALT});
    chk("halted_cnt", {4'b0, bus.stall_cycles}, 8'd3);
    do_reset();
    bus.id_halt = 1'b1;
    tick();
    #1;
    chk("drain_pre", {2'b0, ctl}, {2'b0, STALL});
    reset_n = 1'b0;
    #1;
    chk("drain_rst_ctl", {2'b0, ctl}, {2'b0, ZERO});
    chk("drain_rst_cnt", {4'b0, bus.stall_cycles}, 8'd0);
    tick();
    idle();
    reset_n = 1'b1;
    @(negedge clk);
    chk("drain_rst_run", {2'b0, ctl}, {2'b0, RUNC});
    chk("drain_rst_cnt2", {4'b0, bus.stall_cycles}, 8'd0);
    do_reset();
    load_hazard(2'd0);
    repeat (14) tick();
    @(negedge clk);
    chk("sat_14", {4'b0, bus.stall_cycles}, 8'd14);
    repeat (6) tick();
    @(negedge clk);
    chk("sat_hold", {4'b0, bus.stall_cycles}, 8'd15);
    chk("sat_ctl", {2'b0, ctl}, {2'b0, STALL});
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
